// File: rtl/io_slave_pkg.sv
// Shared types and helpers for the I/O bus slave responder.
// Optional feature macro: IOS_ACK_WR_EN (write ack bypasses wait states).
package io_slave_pkg;

  localparam int DATA_W = 64;
  localparam int SEL_W  = 8;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } state_e;

  // Replace only the byte lanes whose select bit is set.
  function automatic logic [DATA_W-1:0] byte_merge(
    input logic [DATA_W-1:0] old_v,
    input logic [DATA_W-1:0] new_v,
    input logic [SEL_W-1:0]  sel
  );
    logic [DATA_W-1:0] res;
    res = old_v;
    for (int b = 0; b < SEL_W; b++) begin
      if (sel[b]) res[b*8 +: 8] = new_v[b*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/io_slave_regbank.sv
// NREG x 64-bit control register bank with byte-lane writes and a read mux
// that substitutes device status words for slots flagged in STSMASK.
module io_slave_regbank
  import io_slave_pkg::*;
#(
  parameter int               NREG    = 8,
  parameter logic [NREG-1:0]  STSMASK = '0,
  localparam int              IDX_W   = $clog2(NREG)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     we_i,
  input  logic [IDX_W-1:0]         widx_i,
  input  logic [SEL_W-1:0]         sel_i,
  input  logic [DATA_W-1:0]        wdat_i,
  input  logic [IDX_W-1:0]         ridx_i,
  input  logic [NREG*DATA_W-1:0]   sts_i,
  output logic [DATA_W-1:0]        rdat_o,
  output logic [NREG*DATA_W-1:0]   regs_o
);

  logic [DATA_W-1:0] slot_rd [NREG];

  for (genvar gi = 0; gi < NREG; gi++) begin : g_slot
    logic [DATA_W-1:0] slot_q;

    // Status-mapped slots never store; the write still reaches the device as a strobe.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        slot_q <= '0;
      end else if (we_i && (widx_i == IDX_W'(gi)) && !STSMASK[gi]) begin
        slot_q <= byte_merge(slot_q, wdat_i, sel_i);
      end
    end

    assign regs_o[gi*DATA_W +: DATA_W] = slot_q;
    assign slot_rd[gi] = STSMASK[gi] ? sts_i[gi*DATA_W +: DATA_W] : slot_q;
  end

  assign rdat_o = slot_rd[ridx_i];

endmodule

// File: rtl/io_slave_responder.sv
// Device-side responder: decode, programmable wait states, ack held until strobe drops.
// Optional feature macro: IOS_ACK_WR_EN (writes are acked without wait states).
module io_slave_responder
  import io_slave_pkg::*;
#(
  parameter int               NREG        = 8,
  parameter int               WAIT_STATES = 0,
  parameter logic [NREG-1:0]  STSMASK     = '0
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     cs_i,
  input  logic                     cyc_i,
  input  logic                     stb_i,
  output logic                     ack_o,
  input  logic                     we_i,
  input  logic [SEL_W-1:0]         sel_i,
  input  logic [31:0]              adr_i,
  input  logic [DATA_W-1:0]        dat_i,
  output logic [DATA_W-1:0]        dat_o,
  output logic [NREG*DATA_W-1:0]   reg_o,
  output logic [NREG-1:0]          wr_o,
  output logic [NREG-1:0]          rd_o,
  input  logic [NREG*DATA_W-1:0]   sts_i
);

  localparam int IDX_W = $clog2(NREG);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d, cnt_load;
  logic                we_q;
  logic [SEL_W-1:0]    sel_q;
  logic [IDX_W-1:0]    idx_q;
  logic [DATA_W-1:0]   wdat_q;
  logic [DATA_W-1:0]   rdat_q;
  logic [NREG-1:0]     wr_q, wr_d, rd_q, rd_d;
  logic [NREG-1:0]     idx_onehot;
  logic [DATA_W-1:0]   rdat_bank;
  logic                req, ack_entry, in_range, bank_we;
  logic                unused_adr;

  assign req        = cs_i & cyc_i & stb_i;
  assign in_range   = ({{(32-IDX_W){1'b0}}, idx_q} < 32'(NREG));
  assign idx_onehot = NREG'(1) << idx_q;
  assign unused_adr = ^{adr_i[31:3+IDX_W], adr_i[2:0]};

`ifdef IOS_ACK_WR_EN
  assign cnt_load = we_i ? '0 : CNT_W'(WAIT_STATES);
`else
  assign cnt_load = CNT_W'(WAIT_STATES);
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      idx_q   <= '0;
      wdat_q  <= '0;
      rdat_q  <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      if (state_q == ST_IDLE && req) begin
        we_q   <= we_i;
        sel_q  <= sel_i;
        idx_q  <= adr_i[3 +: IDX_W];
        wdat_q <= dat_i;
      end
      if (ack_entry) rdat_q <= (!we_q && in_range) ? rdat_bank : '0;
    end
  end

  // WAIT is always visited once so ack lands WAIT_STATES+1 edges after capture.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ack_entry = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          state_d = ST_WAIT;
          cnt_d   = cnt_load;
        end
      end
      ST_WAIT: begin
        if (!cyc_i) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d   = ST_ACK;
          ack_entry = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_ACK: begin
        if (!stb_i || !cyc_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    bank_we = ack_entry && we_q && in_range;
    wr_d    = bank_we ? idx_onehot : '0;
    rd_d    = (ack_entry && !we_q && in_range) ? idx_onehot : '0;
  end

  always_comb begin
    ack_o = (state_q == ST_ACK);
    dat_o = ack_o ? rdat_q : '0;
    wr_o  = wr_q;
    rd_o  = rd_q;
  end

  io_slave_regbank #(
    .NREG    (NREG),
    .STSMASK (STSMASK)
  ) u_regbank (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .we_i   (bank_we),
    .widx_i (idx_q),
    .sel_i  (sel_q),
    .wdat_i (wdat_q),
    .ridx_i (idx_q),
    .sts_i  (sts_i),
    .rdat_o (rdat_bank),
    .regs_o (reg_o)
  );

endmodule

// File: tb/tb_io_slave_responder.sv
// Directed bench: one zero-wait-state responder with a status slot, one with three wait states.
module tb_io_slave_responder;

`ifdef IOS_ACK_WR_EN
  localparam int   WR_LAT3   = 1;
  localparam logic ABORT_WE  = 1'b0;
`else
  localparam int   WR_LAT3   = 4;
  localparam logic ABORT_WE  = 1'b1;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         cs0 = 1'b0, cs3 = 1'b0, cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [7:0]   sel = '0;
  logic [31:0]  adr = '0;
  logic [63:0]  wdat = '0;
  logic [511:0] sts0, sts3;
  logic         ack0, ack3;
  logic [63:0]  dat0, dat3;
  logic [511:0] reg0, reg3;
  logic [7:0]   wr0, wr3, rd0, rd3;

  logic         use3 = 1'b0;
  logic         ack_m;
  logic [63:0]  dat_m;
  logic [7:0]   wr_m, rd_m;
  logic [511:0] reg_m;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  initial begin
    sts0 = {8{64'hDEAD_BEEF_0BAD_F00D}};
    sts0[63:0] = 64'h0000_0000_0000_CAFE;
    sts3 = {8{64'hFFFF_FFFF_FFFF_FFFF}};
  end

  assign ack_m = use3 ? ack3 : ack0;
  assign dat_m = use3 ? dat3 : dat0;
  assign wr_m  = use3 ? wr3  : wr0;
  assign rd_m  = use3 ? rd3  : rd0;
  assign reg_m = use3 ? reg3 : reg0;

  io_slave_responder #(.NREG(8), .WAIT_STATES(0), .STSMASK(8'h01)) dut0 (
    .clk_i(clk), .rst_i(rst), .cs_i(cs0), .cyc_i(cyc), .stb_i(stb), .ack_o(ack0),
    .we_i(we), .sel_i(sel), .adr_i(adr), .dat_i(wdat), .dat_o(dat0),
    .reg_o(reg0), .wr_o(wr0), .rd_o(rd0), .sts_i(sts0)
  );

  io_slave_responder #(.NREG(8), .WAIT_STATES(3), .STSMASK(8'h00)) dut3 (
    .clk_i(clk), .rst_i(rst), .cs_i(cs3), .cyc_i(cyc), .stb_i(stb), .ack_o(ack3),
    .we_i(we), .sel_i(sel), .adr_i(adr), .dat_i(wdat), .dat_o(dat3),
    .reg_o(reg3), .wr_o(wr3), .rd_o(rd3), .sts_i(sts3)
  );

  typedef struct {
    bit          d3;
    logic        we;
    logic [7:0]  sel;
    logic [31:0] adr;
    logic [63:0] wd;
    logic [63:0] exp_val;   // write: slot contents afterwards; read: dat_o
    int          exp_lat;
    logic [7:0]  exp_wr;
    logic [7:0]  exp_rd;
  } vec_t;

  vec_t vecs [13];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Full handshake: request, wait for ack (bounded), hold stb for `hold` ack cycles, release.
  task automatic xfer(input bit d3, input logic w, input logic [7:0] s, input logic [31:0] a,
                      input logic [63:0] d, input int hold,
                      output int lat, output logic [63:0] rdv, output logic [7:0] wrp,
                      output logic [7:0] rdp, output int ack_cnt, output logic ack_after,
                      output logic [63:0] dat_after, output logic [7:0] pulse_after);
    use3 = d3; cs0 = !d3; cs3 = d3; cyc = 1'b1; stb = 1'b1;
    we = w; sel = s; adr = a; wdat = d;
    @(posedge clk); #1;
    cs0 = 1'b0; cs3 = 1'b0;
    lat = 0;
    while (!ack_m && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    rdv = dat_m; wrp = wr_m; rdp = rd_m;
    ack_cnt = 0;
    for (int c = 0; c < hold; c++) begin
      if (ack_m) ack_cnt++;
      if (c < hold - 1) begin
        @(posedge clk); #1;
      end
    end
    cyc = 1'b0; stb = 1'b0;
    @(posedge clk); #1;
    ack_after = ack_m; dat_after = dat_m; pulse_after = wr_m | rd_m;
  endtask

  initial begin
    int          lat, ack_cnt;
    logic [63:0] rdv, dat_after;
    logic [7:0]  wrp, rdp, pulse_after;
    logic        ack_after, ack_seen, wr_seen;
    int          slot;
    string       tag;

    vecs[0]  = '{0, 1'b1, 8'hFF, 32'h18,   64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, 1, 8'h08, 8'h00};
    vecs[1]  = '{0, 1'b0, 8'hFF, 32'h18,   64'h0,                   64'h0123_4567_89AB_CDEF, 1, 8'h00, 8'h08};
    vecs[2]  = '{0, 1'b1, 8'h0C, 32'h08,   64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_FFFF_0000, 1, 8'h02, 8'h00};
    vecs[3]  = '{0, 1'b0, 8'h00, 32'h1008, 64'h0,                   64'h0000_0000_FFFF_0000, 1, 8'h00, 8'h02};
    vecs[4]  = '{0, 1'b0, 8'hFF, 32'h00,   64'h0,                   64'h0000_0000_0000_CAFE, 1, 8'h00, 8'h01};
    vecs[5]  = '{0, 1'b1, 8'hFF, 32'h00,   64'h1234,                64'h0,                   1, 8'h01, 8'h00};
    vecs[6]  = '{0, 1'b0, 8'hFF, 32'h00,   64'h0,                   64'h0000_0000_0000_CAFE, 1, 8'h00, 8'h01};
    vecs[7]  = '{0, 1'b1, 8'h00, 32'h38,   64'hAAAA_AAAA_AAAA_AAAA, 64'h0,                   1, 8'h80, 8'h00};
    vecs[8]  = '{0, 1'b1, 8'h81, 32'h38,   64'h1122_3344_5566_7788, 64'h1100_0000_0000_0088, 1, 8'h80, 8'h00};
    vecs[9]  = '{0, 1'b0, 8'hFF, 32'h3C,   64'h0,                   64'h1100_0000_0000_0088, 1, 8'h00, 8'h80};
    vecs[10] = '{1, 1'b1, 8'hFF, 32'h10,   64'h5555_AAAA_5555_AAAA, 64'h5555_AAAA_5555_AAAA, WR_LAT3, 8'h04, 8'h00};
    vecs[11] = '{1, 1'b0, 8'hFF, 32'h10,   64'h0,                   64'h5555_AAAA_5555_AAAA, 4, 8'h00, 8'h04};
    vecs[12] = '{1, 1'b1, 8'hF0, 32'h10,   64'h0123_4567_89AB_CDEF, 64'h0123_4567_5555_AAAA, WR_LAT3, 8'h04, 8'h00};

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset ack",  {62'h0, ack3, ack0}, 64'h0);
    chk("reset dat",  dat0 | dat3, 64'h0);
    chk("reset pulses", {32'h0, wr0, rd0, wr3, rd3}, 64'h0);
    chk("reset regs", {63'h0, (reg0 == '0) && (reg3 == '0)}, 64'h1);

    for (int i = 0; i < 13; i++) begin
      xfer(vecs[i].d3, vecs[i].we, vecs[i].sel, vecs[i].adr, vecs[i].wd, 1,
           lat, rdv, wrp, rdp, ack_cnt, ack_after, dat_after, pulse_after);
      slot = int'(vecs[i].adr[5:3]);
      tag = $sformatf("v%0d", i);
      chk({tag, " latency"}, 64'(lat), 64'(vecs[i].exp_lat));
      if (vecs[i].we) chk({tag, " slot"}, reg_m[slot*64 +: 64], vecs[i].exp_val);
      else            chk({tag, " rdata"}, rdv, vecs[i].exp_val);
      chk({tag, " wr_o"}, 64'(wrp), 64'(vecs[i].exp_wr));
      chk({tag, " rd_o"}, 64'(rdp), 64'(vecs[i].exp_rd));
      chk({tag, " ack release"}, {63'h0, ack_after}, 64'h0);
      chk({tag, " dat release"}, dat_after, 64'h0);
      chk({tag, " pulse width"}, 64'(pulse_after), 64'h0);
    end

    // Abort: cyc drops during the wait states of a slot-4 access on the 3-wait-state device.
    use3 = 1'b1; cs3 = 1'b1; cyc = 1'b1; stb = 1'b1;
    we = ABORT_WE; sel = 8'hFF; adr = 32'h20; wdat = 64'h7777_7777_7777_7777;
    @(posedge clk); #1;
    cs3 = 1'b0;
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0;
    ack_seen = 1'b0; wr_seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      ack_seen |= ack3;
      wr_seen  |= (wr3 != 8'h00) || (rd3 != 8'h00);
    end
    chk("abort ack", {63'h0, ack_seen}, 64'h0);
    chk("abort pulse", {63'h0, wr_seen}, 64'h0);
    chk("abort slot", reg3[4*64 +: 64], 64'h0);
    xfer(1, 1'b0, 8'hFF, 32'h20, 64'h0, 1, lat, rdv, wrp, rdp, ack_cnt, ack_after, dat_after, pulse_after);
    chk("post-abort latency", 64'(lat), 64'd4);
    chk("post-abort rd_o", 64'(rdp), 64'h10);

    // Ack held for as long as strobe stays high.
    xfer(1, 1'b0, 8'hFF, 32'h10, 64'h0, 5, lat, rdv, wrp, rdp, ack_cnt, ack_after, dat_after, pulse_after);
    chk("hold latency", 64'(lat), 64'd4);
    chk("hold ack cycles", 64'(ack_cnt), 64'd5);
    chk("hold rdata", rdv, 64'h0123_4567_5555_AAAA);
    chk("hold release", {63'h0, ack_after}, 64'h0);

    // Asynchronous reset while acking: ack drops without waiting for a clock edge.
    use3 = 1'b1; cs3 = 1'b1; cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h10;
    @(posedge clk); #1;
    cs3 = 1'b0;
    lat = 0;
    while (!ack3 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("pre-reset ack", {63'h0, ack3}, 64'h1);
    #2 rst = 1'b1;
    #1;
    chk("reset ack immediate", {63'h0, ack3}, 64'h0);
    chk("reset dat immediate", dat3, 64'h0);
    chk("reset clears regs", {63'h0, (reg0 == '0) && (reg3 == '0)}, 64'h1);
    cyc = 1'b0; stb = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    xfer(0, 1'b0, 8'hFF, 32'h18, 64'h0, 1, lat, rdv, wrp, rdp, ack_cnt, ack_after, dat_after, pulse_after);
    chk("post-reset rdata", rdv, 64'h0);
    chk("post-reset latency", 64'(lat), 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
